// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, and
// datapath select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StRExec,
        StRWb,
        StIExec,
        StIWb,
        StBranch,
        StJump,
        StJal,
        StJr
    } state_e;

    localparam logic [5:0] R_TYPE   = 6'h00;
    localparam logic [5:0] ADDI     = 6'h08;
    localparam logic [5:0] ORI      = 6'h0D;
    localparam logic [5:0] LW       = 6'h23;
    localparam logic [5:0] SW       = 6'h2B;
    localparam logic [5:0] BEQ      = 6'h04;
    localparam logic [5:0] BNE      = 6'h05;
    localparam logic [5:0] J        = 6'h02;
    localparam logic [5:0] JAL      = 6'h03;
    localparam logic [5:0] JR_FUNCT = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'd0;
    localparam logic [1:0] MEM_TO_REG_MDR    = 2'd1;
    localparam logic [1:0] MEM_TO_REG_PC     = 2'd2;

    localparam logic [1:0] SRC_B_RT        = 2'd0;
    localparam logic [1:0] SRC_B_FOUR      = 2'd1;
    localparam logic [1:0] SRC_B_IMM       = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SHIFT = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] opcode);
        case (opcode)
            R_TYPE, ADDI, ORI, LW, SW, BEQ, BNE, J, JAL: is_legal = 1'b1;
            default:                                     is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_output_decode.sv
// Combinational map from controller state (plus opcode, zero flag and memory
// ready) to every datapath control signal.
module mips_ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            StDecode: begin
                // Branch target lands in ALUOut while the opcode is dispatched.
                ctrl.alu_src_b = SRC_B_IMM_SHIFT;
                ctrl.alu_op    = ALU_ADD;
                ctrl.illegal   = ~is_legal(opcode);
            end
            StMemAddr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = MEM_TO_REG_MDR;
                ctrl.done       = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.done      = mem_ready;
            end
            StRExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_RTYPE;
            end
            StRWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RD;
                ctrl.mem_to_reg = MEM_TO_REG_ALUOUT;
                ctrl.done       = 1'b1;
            end
            StIExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = (opcode == ORI) ? ALU_ORI : ALU_ADDI;
            end
            StIWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = MEM_TO_REG_ALUOUT;
                ctrl.done       = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PC_SRC_ALUOUT;
                ctrl.pc_write  = (opcode == BNE) ? ~zero : zero;
                ctrl.done      = 1'b1;
            end
            StJump: begin
                ctrl.pc_source = PC_SRC_JUMP;
                ctrl.pc_write  = 1'b1;
                ctrl.done      = 1'b1;
            end
            StJal: begin
                // PC already holds PC+4, which is the return address for $31.
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RA;
                ctrl.mem_to_reg = MEM_TO_REG_PC;
                ctrl.done       = 1'b1;
            end
            StJr: begin
                ctrl.pc_source = PC_SRC_RS;
                ctrl.pc_write  = 1'b1;
                ctrl.done      = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS sequencing controller: state register, next-state logic and
// reset gating of the write strobes.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:   if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                case (opcode_i)
                    R_TYPE:    state_d = (funct_i == JR_FUNCT) ? StJr : StRExec;
                    ADDI, ORI: state_d = StIExec;
                    LW, SW:    state_d = StMemAddr;
                    BEQ, BNE:  state_d = StBranch;
                    J:         state_d = StJump;
                    JAL:       state_d = StJal;
                    default:   state_d = StFetch;
                endcase
            end
            StMemAddr: state_d = (opcode_i == SW) ? StMemWr : StMemRd;
            StMemRd:   if (mem_ready_i) state_d = StMemWb;
            StMemWr:   if (mem_ready_i) state_d = StFetch;
            StRExec:   state_d = StRWb;
            StIExec:   state_d = StIWb;
            default:   state_d = StFetch;
        endcase
    end

    mips_ctrl_output_decode u_output_decode (
        .state     (state_q),
        .opcode    (opcode_i),
        .zero      (zero_i),
        .mem_ready (mem_ready_i),
        .ctrl      (ctrl)
    );

    // Write-type strobes are suppressed while reset is held so no state is
    // committed in the cycle the controller is being pulled back to FETCH.
    always_comb begin
        pc_write_o   = ctrl.pc_write & ~reset;
        ir_write_o   = ctrl.ir_write & ~reset;
        reg_write_o  = ctrl.reg_write & ~reset;
        mem_write_o  = ctrl.mem_write & ~reset;
        instr_done_o = ctrl.done & ~reset;
        illegal_o    = ctrl.illegal & ~reset;
        iord_o       = ctrl.iord;
        mem_read_o   = ctrl.mem_read;
        reg_dst_o    = ctrl.reg_dst;
        mem_to_reg_o = ctrl.mem_to_reg;
        alu_src_a_o  = ctrl.alu_src_a;
        alu_src_b_o  = ctrl.alu_src_b;
        alu_op_o     = ctrl.alu_op;
        pc_source_o  = ctrl.pc_source;
    end

endmodule
